score_digits_ctrl: RTL and testbench
====================================

// Module: score_digits_ctrl
// PURPOSE
//  Sequencer/arbiter for the shared digit-sprite ROM in the score overlay. Accepts a binary score,
//  converts it to 4 BCD digits with a multi-cycle shift-add-3 FSM, and commits the digits only at a
//  frame boundary, so the display never tears. Each pixel, selects the digit slot under hcount/vcount,
//  drives one shared ROM address, and returns an aligned pixel and overlap flag to the VGA mixer.
// PARAMETERS
//  WIDTH        25     digit glyph width, pixels
//  HEIGHT       52     digit glyph height, pixels
//  X0           11'd0  left x of slot 0 (most significant digit)
//  Y0           10'd0  top y of all slots
//  GAP          4      blank pixels between slots
//  UPDATE_LINE  768    vcount on which pending digits commit (first blanking line)
//  COLOR        12'hFFF pixel colour for a set ROM bit
// PORTS
//  pixel_clk    in   1   pixel clock; the only clock
//  reset        in   1   asynchronous, active-high reset
//  value        in   14  binary score
//  value_valid  in   1   value offered
//  value_ready  out  1   converter idle; value accepted on valid&&ready
//  hcount       in   11  current pixel x
//  vcount       in   10  current pixel y
//  rom_addr     out  14  shared glyph ROM address = digit*WIDTH*HEIGHT + row*WIDTH + col
//  rom_data     in   1   glyph bit, synchronous ROM, 1-cycle read latency
//  pixel        out  12  COLOR if overlap && rom_data, else 0
//  overlap      out  1   pixel lies inside a displayed digit slot
// BEHAVIOUR
//  Reset: FSM=IDLE, value_ready=1, committed and pending digits=0000, pending_flag=0, rom_addr=0, pixel=0,
//   overlap=0, pipeline valid bits=0. Reset during CONVERT aborts the conversion; nothing is committed.
//  FSM: IDLE --valid&&ready--> CONVERT. In CONVERT, each cycle does add-3 on BCD nibbles >=5, then shifts left 1.
//   After exactly 14 cycles --> IDLE, result to pending, pending_flag=1. value_ready=1 only in IDLE.
//   value_valid during CONVERT is ignored; the source must hold it until ready.
//  Clamp: value>9999 is converted as 9999.
//  Newer pending overwrites older: only the last completed conversion before a commit is shown.
//  Commit: on the cycle hcount==0 && vcount==UPDATE_LINE with pending_flag=1, committed<=pending and pending_flag<=0.
//   If a conversion finishes in that same cycle, the new result goes to pending and commits next frame.
//  Slot i (0..3): x in [X0+i*(WIDTH+GAP), X0+i*(WIDTH+GAP)+WIDTH), y in [Y0, Y0+HEIGHT).
//   Bounds are half-open; gap columns are outside.
//  Pipeline: S1 (t+1): rom_addr registered; slot-hit registered. ROM data valid at t+2.
//   S2 (t+2): pixel and overlap registered with rom_data. Total latency is 2 cycles from hcount/vcount to pixel/overlap.
//  Outside all slots: rom_addr=0, overlap=0 at t+2, pixel=0.
//  Arithmetic: row*WIDTH and digit*WIDTH*HEIGHT use 14-bit unsigned. Max address 9*1300+1299=12999.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: leading-zero digits in slots 0..2 are blanked (overlap=0, pixel=0).
//   Slot 3 always shows, so a value of 0 shows a single "0".
//  Not defined: all 4 slots always show, zero-padded (e.g. 0007).
// STRUCTURE
//  Package digit_pkg: WIDTH, HEIGHT, NDIG=4, GLYPH_WORDS=WIDTH*HEIGHT, ROM_AW=14,
//   FSM state encoding (IDLE, CONVERT), and the BCD digit type (4-bit).
//  Sub-module bin2bcd_seq holds the 14-cycle shift-add-3 FSM, clamp, and valid/ready handshake.
//  The top holds pending/commit registers, slot decode, address generation and the 2-stage pipeline.
// TESTING
//  1 Reset with valid idle -> value_ready=1, overlap=0, pixel=0; an in-slot scan shows digits 0,0,0,0 (rom_addr uses digit 0).
//  2 value=1234 for 1 cycle -> ready low for 14 cycles then high. After the UPDATE_LINE commit,
//     hcount=X0+29+3, vcount=Y0+2 -> rom_addr=2*1300+53=2653 at t+1.
//  3 value=12000 -> clamped to 9999; slot 0 at col 0, row 0 -> rom_addr=11700.
//  4 value=5, then value=42, both before the commit line -> the frame after commit shows 0042. A commit-cycle completion shows next frame.
//  5 reset asserted during the 7th CONVERT cycle -> value_ready=1 asynchronously; committed stays 0000; no commit on the next frame.
//  6 hcount=X0+24 -> overlap=1 at t+2; hcount=X0+25 (gap) -> overlap=0. With LEADING_ZERO_BLANK_EN and value=7,
//     slots 0-2 have overlap=0 and slot 3 has overlap=1; without the macro, all four slots have overlap=1.

Source files
------------

// File: rtl/digit_pkg.sv
// Shared constants, FSM encoding and digit types for the score digit overlay.
// Glyph ROM layout: digit-major, then row-major, WIDTH*HEIGHT bits per glyph.
package digit_pkg;
    localparam int WIDTH       = 25;
    localparam int HEIGHT      = 52;
    localparam int NDIG        = 4;
    localparam int GLYPH_WORDS = WIDTH * HEIGHT;
    localparam int ROM_AW      = 14;
    localparam int VAL_W       = 14;

    localparam logic [VAL_W-1:0] VAL_MAX = 14'd9999;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } conv_state_e;

    typedef logic [3:0] bcd_t;
    // Index NDIG-1 holds the thousands digit (shown in slot 0).
    typedef bcd_t [NDIG-1:0] bcd_vec_t;

    function automatic logic [ROM_AW-1:0] glyph_addr(bcd_t d, logic [ROM_AW-1:0] row,
                                                     logic [ROM_AW-1:0] col);
        logic [ROM_AW-1:0] base;
        base = ROM_AW'(d) * ROM_AW'(GLYPH_WORDS);
        return base + row * ROM_AW'(WIDTH) + col;
    endfunction
endpackage

// File: rtl/score_digits_ctrl_if.sv
// Score source, raster position, glyph ROM and mixer signals of the score overlay.
// master = surrounding system (score source, VGA timing, ROM, mixer); slave = the controller.
interface score_digits_ctrl_if;
    import digit_pkg::*;

    logic [VAL_W-1:0]  value;
    logic              value_valid;
    logic              value_ready;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_data;
    logic [11:0]       pixel;
    logic              overlap;

    modport master (
        output value, value_valid, hcount, vcount, rom_data,
        input  value_ready, rom_addr, pixel, overlap
    );

    modport slave (
        input  value, value_valid, hcount, vcount, rom_data,
        output value_ready, rom_addr, pixel, overlap
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// Values above 9999 are clamped; done_o pulses with the result on bcd_o.
module bin2bcd_seq
    import digit_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [VAL_W-1:0] value_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             done_o,
    output bcd_vec_t         bcd_o
);
    localparam int CNT_W = $clog2(VAL_W);

    conv_state_e      state_q, state_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    bcd_vec_t         bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        assign adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        ready_o = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = CONVERT;
                    bin_d   = (value_i > VAL_MAX) ? VAL_MAX : value_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result is taken from the final shift so it lands in the same cycle FSM returns to IDLE.
    assign bcd_o = bcd_d;
endmodule

// File: rtl/score_digits_ctrl.sv
// Score overlay: BCD conversion, tear-free commit at UPDATE_LINE, slot decode and 2-stage glyph ROM pipeline.
// Optional LEADING_ZERO_BLANK_EN: blank leading-zero digits in slots 0..NDIG-2.
module score_digits_ctrl
    import digit_pkg::*;
#(
    parameter logic [10:0] X0          = 11'd0,
    parameter logic [9:0]  Y0          = 10'd0,
    parameter int          GAP         = 4,
    parameter int          UPDATE_LINE = 768,
    parameter logic [11:0] COLOR       = 12'hFFF
) (
    input  logic               pixel_clk,
    input  logic               reset,
    score_digits_ctrl_if.slave bus
);
    localparam int PITCH  = WIDTH + GAP;
    localparam int STAGES = 2;

    logic     conv_done;
    bcd_vec_t conv_bcd;

    bin2bcd_seq u_conv (
        .clk_i   (pixel_clk),
        .rst_i   (reset),
        .value_i (bus.value),
        .valid_i (bus.value_valid),
        .ready_o (bus.value_ready),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    bcd_vec_t pend_q, pend_d, comm_q, comm_d;
    logic     pend_flag_q, pend_flag_d;
    logic     commit;

    assign commit = pend_flag_q && (bus.hcount == 11'd0) && (bus.vcount == 10'(UPDATE_LINE));

    // A conversion finishing on the commit cycle stays pending for the next frame.
    always_comb begin
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        comm_d      = comm_q;
        if (commit) begin
            comm_d      = pend_q;
            pend_flag_d = 1'b0;
        end
        if (conv_done) begin
            pend_d      = conv_bcd;
            pend_flag_d = 1'b1;
        end
    end

    logic [NDIG-1:0]              hit, show;
    logic [NDIG-1:0][ROM_AW-1:0]  slot_addr;

    for (genvar i = 0; i < NDIG; i++) begin : g_slot
        localparam int XS = int'(X0) + i * PITCH;
        logic [11:0] dx;
        logic [10:0] dy;

        assign dx = {1'b0, bus.hcount} - 12'(XS);
        assign dy = {1'b0, bus.vcount} - {1'b0, Y0};
        assign hit[i] = ({1'b0, bus.hcount} >= 12'(XS)) && (dx < 12'(WIDTH)) &&
                        (bus.vcount >= Y0) && (dy < 11'(HEIGHT));
        assign slot_addr[i] = glyph_addr(comm_q[NDIG-1-i], ROM_AW'(dy), ROM_AW'(dx));

`ifdef LEADING_ZERO_BLANK_EN
        if (i < NDIG - 1) begin : g_blank
            // Visible once any digit from the most significant down to this one is non-zero.
            assign show[i] = |comm_q[NDIG-1 -: i+1];
        end else begin : g_keep
            assign show[i] = 1'b1;
        end
`else
        assign show[i] = 1'b1;
`endif
    end

    logic [ROM_AW-1:0] addr_d, rom_addr_q;
    logic              ov_d, s1_ov_q, ov_q;
    logic [STAGES:1]   vld_pipe_q;

    always_comb begin
        addr_d = '0;
        ov_d   = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (hit[i]) begin
                addr_d = slot_addr[i];
                ov_d   = show[i];
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pend_q      <= '0;
            comm_q      <= '0;
            pend_flag_q <= 1'b0;
            rom_addr_q  <= '0;
            s1_ov_q     <= 1'b0;
            ov_q        <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            comm_q      <= comm_d;
            pend_flag_q <= pend_flag_d;
            rom_addr_q  <= addr_d;
            s1_ov_q     <= ov_d;
            ov_q        <= s1_ov_q & vld_pipe_q[1];
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:1], 1'b1};
        end
    end

    logic ov_out;
    assign ov_out       = ov_q & vld_pipe_q[STAGES];
    assign bus.rom_addr = rom_addr_q;
    assign bus.overlap  = ov_out;
    // ROM data arrives in the same cycle as ov_q, so the colour gate is combinational.
    assign bus.pixel    = (ov_out && bus.rom_data) ? COLOR : 12'h000;
endmodule

// File: tb/tb_score_digits_ctrl.sv
// Randomized scoreboard bench for score_digits_ctrl against a value-level model of the overlay.
`timescale 1ns/1ps
module tb_score_digits_ctrl;
    import digit_pkg::*;

    localparam int X0 = 0, Y0 = 0, PITCH = 29, UPD = 768;

    logic pixel_clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0, checks = 0;

    score_digits_ctrl_if bus();

    score_digits_ctrl #(.X0(11'd0), .Y0(10'd0), .GAP(4), .UPDATE_LINE(768), .COLOR(12'hFFF)) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    function automatic logic rom_bit(int a);
        return a[0] ^ a[2] ^ a[5] ^ a[9] ^ a[13];
    endfunction

    always @(posedge pixel_clk) bus.rom_data <= rom_bit(int'(bus.rom_addr));

    // Model: values held as plain integers, conversion as a countdown.
    int m_comm = 0, m_pend = 0, m_val = 0, m_left = 0;
    bit m_flag = 0, m_busy = 0;

    function automatic int p10(int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic void expect_at(int h, int v, output int addr, output bit ov);
        addr = 0;
        ov   = 0;
        for (int i = 0; i < NDIG; i++) begin
            int xs = X0 + i * PITCH;
            if (h >= xs && h < xs + WIDTH && v >= Y0 && v < Y0 + HEIGHT) begin
                int d = (m_comm / p10(3 - i)) % 10;
                addr = d * GLYPH_WORDS + (v - Y0) * WIDTH + (h - xs);
                ov   = 1;
`ifdef LEADING_ZERO_BLANK_EN
                if (i < 3 && m_comm < p10(3 - i)) ov = 0;
`endif
            end
        end
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct { int due; int addr; bit ov; int pix; } exp_t;
    exp_t qa[$];
    exp_t qp[$];

    always @(negedge pixel_clk) begin
        exp_t e;
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            if (e.due != cyc) chk("sb_addr_late", e.due, cyc);
            else chk("rom_addr", int'(bus.rom_addr), e.addr);
        end
        while (qp.size() > 0 && qp[0].due <= cyc) begin
            e = qp.pop_front();
            if (e.due != cyc) chk("sb_pix_late", e.due, cyc);
            else begin
                chk("overlap", int'(bus.overlap), int'(e.ov));
                chk("pixel", int'(bus.pixel), e.pix);
            end
        end
    end

    task automatic model_step();
        if (reset) begin
            m_comm = 0; m_pend = 0; m_flag = 0; m_busy = 0;
            return;
        end
        if (bus.hcount == 11'd0 && int'(bus.vcount) == UPD && m_flag) begin
            m_comm = m_pend;
            m_flag = 0;
        end
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_pend = m_val;
                m_flag = 1;
            end
        end else if (bus.value_valid) begin
            m_busy = 1;
            m_left = 14;
            m_val  = (int'(bus.value) > 9999) ? 9999 : int'(bus.value);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        model_step();
        #1;
    endtask

    task automatic set_pos(int h, int v);
        exp_t e;
        int   a;
        bit   o;
        bus.hcount = 11'(h);
        bus.vcount = 10'(v);
        expect_at(h, v, a, o);
        e.addr = a;
        e.ov   = o;
        e.pix  = (o && rom_bit(a)) ? 12'hFFF : 0;
        e.due  = cyc + 1;
        qa.push_back(e);
        e.due  = cyc + 2;
        qp.push_back(e);
    endtask

    task automatic idle_pos();
        set_pos(600, 300);
        tick();
    endtask

    task automatic commit_line();
        set_pos(0, UPD);
        tick();
        idle_pos();
    endtask

    task automatic submit(int val);
        chk("ready_before_accept", int'(bus.value_ready), 1);
        bus.value = 14'(val);
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        chk("ready_after_accept", int'(bus.value_ready), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.value_ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_low_cycles", n, 14);
    endtask

    task automatic scan_slots();
        for (int i = 0; i < NDIG; i++) begin
            int xs = X0 + i * PITCH;
            set_pos(xs, Y0); tick();
            set_pos(xs + WIDTH - 1, Y0 + HEIGHT - 1); tick();
            set_pos(xs + int'($urandom_range(0, WIDTH - 1)), Y0 + int'($urandom_range(0, HEIGHT - 1))); tick();
            set_pos(xs + WIDTH, Y0 + 5); tick();
        end
        idle_pos(); tick(); tick();
    endtask

    // Submit a value timed so its conversion completes on the commit-line cycle.
    task automatic submit_on_commit(int val);
        submit(val);
        repeat (13) tick();
        set_pos(0, UPD);
        tick();
        chk("ready_after_commit_finish", int'(bus.value_ready), 1);
        idle_pos();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ov;
        bus.value = '0;
        bus.value_valid = 1'b0;
        bus.hcount = 11'd600;
        bus.vcount = 10'd300;

        // Reset state
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_ready", int'(bus.value_ready), 1);
        chk("rst_overlap", int'(bus.overlap), 0);
        chk("rst_pixel", int'(bus.pixel), 0);
        chk("rst_rom_addr", int'(bus.rom_addr), 0);
        reset = 1'b0;
        idle_pos();
        scan_slots();
        commit_line();
        scan_slots();

        // 1234 -> slot 1, col 3, row 2
        submit(1234);
        wait_ready();
        commit_line();
        set_pos(X0 + 29 + 3, Y0 + 2);
        tick();
        chk("addr_1234_slot1", int'(bus.rom_addr), 2653);
        idle_pos(); tick();
        scan_slots();

        // Clamp
        submit(12000);
        wait_ready();
        scan_slots();
        commit_line();
        set_pos(X0, Y0);
        tick();
        chk("addr_clamp_slot0", int'(bus.rom_addr), 11700);
        idle_pos(); tick();
        scan_slots();

        // Newer pending overwrites older
        submit(5);
        wait_ready();
        submit(42);
        wait_ready();
        scan_slots();
        commit_line();
        set_pos(X0 + 2 * PITCH + 1, Y0);
        tick();
        chk("addr_0042_slot2", int'(bus.rom_addr), 4 * 1300 + 1);
        idle_pos(); tick();
        scan_slots();

        // Completion on the commit cycle with nothing pending, then with something pending
        submit_on_commit(7);
        scan_slots();
        commit_line();
        scan_slots();
        submit(100);
        wait_ready();
        submit_on_commit(9876);
        scan_slots();
        commit_line();
        scan_slots();

        // Slot boundaries
        set_pos(X0 + 24, Y0 + 10); tick();
        set_pos(X0 + 25, Y0 + 10); tick();
        chk("ov_col24", int'(bus.overlap), 1);
        set_pos(X0 + 28, Y0 + 10); tick();
        chk("ov_col25_gap", int'(bus.overlap), 0);
        set_pos(X0 + 3 * PITCH + 24, Y0 + HEIGHT - 1); tick();
        set_pos(X0 + 3 * PITCH + 25, Y0 + HEIGHT - 1); tick();
        set_pos(X0 + 10, Y0 + HEIGHT); tick();
        idle_pos(); tick(); tick();

        // Value 7: leading-zero handling per slot
        submit(7);
        wait_ready();
        commit_line();
        for (int i = 0; i < NDIG; i++) begin
            set_pos(X0 + i * PITCH + 5, Y0 + 5); tick(); tick();
`ifdef LEADING_ZERO_BLANK_EN
            exp_ov = (i == 3) ? 1 : 0;
`else
            exp_ov = 1;
`endif
            chk("ov_value7_slot", int'(bus.overlap), exp_ov);
        end
        idle_pos(); tick(); tick();
        scan_slots();

        // Reset during the 7th CONVERT cycle
        submit(4321);
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        chk("abort_ready_async", int'(bus.value_ready), 1);
        chk("abort_overlap", int'(bus.overlap), 0);
        chk("abort_pixel", int'(bus.pixel), 0);
        m_comm = 0; m_pend = 0; m_flag = 0; m_busy = 0;
        @(posedge pixel_clk);
        #1 reset = 1'b0;
        idle_pos();
        commit_line();
        scan_slots();
        repeat (20) tick();
        chk("abort_ready_stays", int'(bus.value_ready), 1);
        commit_line();
        scan_slots();

        // Randomized conversions and scans
        for (int r = 0; r < 20; r++) begin
            submit(int'($urandom_range(0, 16383)));
            wait_ready();
            if ($urandom_range(0, 3) != 0) commit_line();
            for (int k = 0; k < 30; k++) begin
                set_pos(int'($urandom_range(0, 130)), int'($urandom_range(0, 60)));
                tick();
            end
            idle_pos();
        end

        repeat (4) tick();
        chk("sb_drained", qa.size() + qp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
